// File: rtl/conf_stream_sched_pkg.sv
// Shared FSM encoding and sizing helper for the config stream scheduler.
package conf_stream_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } sched_state_t;

    // Destination index width; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cfg_out_fifo.sv
// Two-entry synchronous FIFO holding tagged config words between the memory
// read port and the config bus.
module cfg_out_fifo #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the two storage entries are reset so the head reads zero straight after reset.
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(i_push) - 2'(i_pop);
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule

// File: rtl/conf_stream_sched.sv
// Round-robin scheduler: grants one region loader at a time and streams its
// program from the shared config memory onto the valid/ready config bus.
module conf_stream_sched
    import conf_stream_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int ADDR_W  = 8,
    parameter  int LEN_W   = 8,
    parameter  int DATA_W  = 32,
    localparam int DST_W   = clog2_min1(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_base,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      cfg_valid,
    input  logic                      cfg_ready,
    output logic [DATA_W-1:0]         cfg_data,
    output logic [DST_W-1:0]          cfg_dst,
    output logic                      busy
);

    sched_state_t       r_state;
    sched_state_t       w_next_state;
    logic [DST_W-1:0]   r_rr_ptr;
    logic [DST_W-1:0]   r_gnt_idx;
    logic [DST_W-1:0]   w_scan;
    logic [DST_W-1:0]   w_pick_idx;
    logic               w_found;
    logic [ADDR_W-1:0]  w_base_arr [NUM_REQ];
    logic [LEN_W-1:0]   w_len_arr  [NUM_REQ];
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_issued;
    logic [LEN_W-1:0]   r_recv;
    logic               r_inflight;
    logic [1:0]         w_fifo_count;
    logic               w_hs;
    logic               w_room;
    logic               w_last_hs;
    logic [NUM_REQ-1:0] w_gnt_onehot;
    logic [DST_W+DATA_W-1:0] w_head;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_base_arr[i] = req_base[i*ADDR_W +: ADDR_W];
        assign w_len_arr[i]  = req_len[i*LEN_W +: LEN_W];
    end

    // First active requester at or above the RR pointer, wrapping upward.
    always_comb begin
        w_found    = 1'b0;
        w_pick_idx = '0;
        w_scan     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = DST_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req[w_scan]) begin
                w_found    = 1'b1;
                w_pick_idx = w_scan;
            end
        end
    end

    assign cfg_valid    = (w_fifo_count != 2'd0);
    assign w_hs         = cfg_valid && cfg_ready;
    // Words already buffered plus the one in flight, less the one leaving now, must fit.
    assign w_room       = ({1'b0, w_fifo_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_hs});
    assign w_last_hs    = w_hs && (r_recv == r_len - LEN_W'(1));
    assign w_gnt_onehot = NUM_REQ'(1) << r_gnt_idx;
    assign busy         = (r_state != ST_IDLE);
    assign mem_addr     = r_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        grant        = '0;
        done         = '0;
        mem_rd_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next_state = (w_len_arr[w_pick_idx] == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                grant     = w_gnt_onehot;
                mem_rd_en = (r_issued < r_len) && w_room;
                if (w_last_hs) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = w_gnt_onehot;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_gnt_idx  <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_recv     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= mem_rd_en;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt_idx <= w_pick_idx;
                        r_addr    <= w_base_arr[w_pick_idx];
                        r_len     <= w_len_arr[w_pick_idx];
                        r_issued  <= '0;
                        r_recv    <= '0;
                    end
                end
                ST_STREAM: begin
                    if (mem_rd_en) begin
                        r_addr   <= r_addr + 1'b1;
                        r_issued <= r_issued + 1'b1;
                    end
                    if (w_hs) begin
                        r_recv <= r_recv + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_rr_ptr <= (r_gnt_idx == DST_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Each word is tagged with its destination as it enters the buffer.
    cfg_out_fifo #(
        .W (DST_W + DATA_W)
    ) u_out_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (r_inflight),
        .i_push_data ({r_gnt_idx, mem_rdata}),
        .i_pop       (w_hs),
        .o_head_data (w_head),
        .o_count     (w_fifo_count)
    );

    assign cfg_dst  = w_head[DST_W+DATA_W-1:DATA_W];
    assign cfg_data = w_head[DATA_W-1:0];

endmodule

// File: tb/tb_conf_stream_sched.sv
// Self-checking bench for conf_stream_sched: random memory contents, random
// bases/lengths/backpressure, checked against a queue-based transfer model.
module tb_conf_stream_sched;

    localparam int N = 4, AW = 8, LW = 8, DW = 32, DSTW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*AW-1:0] req_base;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]  grant, done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          cfg_valid, cfg_ready;
    logic [DW-1:0] cfg_data;
    logic [DSTW-1:0] cfg_dst;
    logic          busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conf_stream_sched #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_base(req_base), .req_len(req_len),
        .grant(grant), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_dst(cfg_dst), .busy(busy)
    );

    // Config memory: read data one cycle after the strobe.
    logic [DW-1:0] mem [256];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    // Sink readiness: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
    int ready_mode = 0;
    int ready_phase = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: cfg_ready = 1'b1;
            1: begin cfg_ready = (ready_phase == 0); ready_phase = (ready_phase + 1) % 3; end
            default: cfg_ready = 1'($urandom_range(0, 1));
        endcase
    end

    typedef struct packed { logic [DSTW-1:0] dst; logic [DW-1:0] data; } word_t;
    word_t         hs_q[$];
    logic [AW-1:0] addr_q[$];
    int            done_q[$];
    int            grant_q[$];
    int            onehot_err, stall_err;
    logic          prev_stall;
    logic [N-1:0]  prev_grant;
    word_t         prev_word;

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Bus observer, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_grant = '0;
        end else begin
            if (cfg_valid && cfg_ready) hs_q.push_back({cfg_dst, cfg_data});
            if (mem_rd_en) addr_q.push_back(mem_addr);
            if (done != '0) done_q.push_back(idx_of(done));
            if (grant != '0 && prev_grant == '0) grant_q.push_back(idx_of(grant));
            if (!$onehot0(grant) || !$onehot0(done) || (grant & done) != '0) onehot_err++;
            if (prev_stall && (!cfg_valid || {cfg_dst, cfg_data} != prev_word)) stall_err++;
            prev_stall = cfg_valid && !cfg_ready;
            prev_word  = {cfg_dst, cfg_data};
            prev_grant = grant;
        end
    end

    // Reference model state: RR pointer and per-requester programs.
    int model_rr;
    int base_of[N];
    int len_of[N];

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic word_t exp_word(input int g, input int j);
        logic [AW-1:0] a;
        a = AW'(base_of[g] + j);
        return {DSTW'(g), mem[a]};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        hs_q.delete(); addr_q.delete(); done_q.delete(); grant_q.delete();
        onehot_err = 0; stall_err = 0;
    endtask

    task automatic set_slot(input int i, input int b, input int l);
        req_base[i*AW +: AW] = AW'(b);
        req_len[i*LW +: LW]  = LW'(l);
        base_of[i] = b % 256;
        len_of[i]  = l;
    endtask

    task automatic wait_dones(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            tick();
            if (done_q.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (grant !== '0) begin failures++; $display("FAIL reset_grant: got %b want 0", grant); end
        checks++; if (done !== '0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
        checks++; if (cfg_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", cfg_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        checks++; if (cfg_data !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", cfg_data); end
        checks++; if (cfg_dst !== '0) begin failures++; $display("FAIL reset_dst: got %h want 0", cfg_dst); end
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_after: busy %b want 0", busy); end
        model_rr = 0;
    endtask

    // All requesters active: RR order, one done per transfer, words in order.
    task automatic test_contention();
        word_t exp_w[$];
        int exp_d[$], exp_g[$];
        int fixed_order[5] = '{0, 1, 2, 3, 0};
        int n, g;
        logic [N-1:0] v;
        bit ok;
        for (int round = 0; round < 2; round++) begin
            v = (round == 0) ? 4'b1111 : N'($urandom_range(1, 15));
            n = (round == 0) ? 5 : 6;
            for (int i = 0; i < N; i++)
                set_slot(i, $urandom_range(0, 255), (round == 0) ? $urandom_range(1, 5) : $urandom_range(0, 4));
            exp_w.delete(); exp_d.delete(); exp_g.delete();
            for (int t = 0; t < n; t++) begin
                g = rr_pick(v, model_rr);
                exp_d.push_back(g);
                if (len_of[g] > 0) exp_g.push_back(g);
                for (int j = 0; j < len_of[g]; j++) exp_w.push_back(exp_word(g, j));
                model_rr = (g + 1) % N;
            end
            clear_logs();
            ready_mode = 2;
            req = v;
            ok = 1'b0;
            for (int c = 0; c < 3000 && !ok; c++) begin
                tick();
                if (done_q.size() >= n) begin req = '0; ok = 1'b1; end
            end
            repeat (4) tick();
            checks++; if (!ok) begin failures++; $display("FAIL contention_timeout: round %0d dones %0d want %0d", round, done_q.size(), n); end
            checks++; if (done_q.size() != n) begin failures++; $display("FAIL contention_done_count: got %0d want %0d", done_q.size(), n); end
            for (int t = 0; t < n && t < done_q.size(); t++) begin
                checks++; if (done_q[t] != exp_d[t]) begin failures++; $display("FAIL contention_done_order[%0d]: got %0d want %0d", t, done_q[t], exp_d[t]); end
            end
            checks++; if (grant_q.size() != exp_g.size()) begin failures++; $display("FAIL contention_grant_count: got %0d want %0d", grant_q.size(), exp_g.size()); end
            for (int t = 0; t < exp_g.size() && t < grant_q.size(); t++) begin
                checks++; if (grant_q[t] != exp_g[t]) begin failures++; $display("FAIL contention_grant_order[%0d]: got %0d want %0d", t, grant_q[t], exp_g[t]); end
                if (round == 0) begin
                    checks++; if (grant_q[t] != fixed_order[t]) begin failures++; $display("FAIL contention_rr_sequence[%0d]: got %0d want %0d", t, grant_q[t], fixed_order[t]); end
                end
            end
            checks++; if (hs_q.size() != exp_w.size()) begin failures++; $display("FAIL contention_word_count: got %0d want %0d", hs_q.size(), exp_w.size()); end
            for (int t = 0; t < exp_w.size() && t < hs_q.size(); t++) begin
                checks++; if (hs_q[t] !== exp_w[t]) begin failures++; $display("FAIL contention_word[%0d]: got %h want %h", t, hs_q[t], exp_w[t]); end
            end
            checks++; if (onehot_err != 0) begin failures++; $display("FAIL contention_onehot: got %0d violations want 0", onehot_err); end
        end
        ready_mode = 0;
    endtask

    task automatic test_single();
        clear_logs();
        set_slot(1, 'h10, 4);
        req = 4'b0010;
        tick();
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL single_grant: got %b want 0010", grant); end
        checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 8'h10) begin failures++; $display("FAIL single_first_read: rd %b addr %h want 1 10", mem_rd_en, mem_addr); end
        req = '0;
        tick();
        checks++; if (cfg_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b want 0", cfg_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (cfg_valid !== 1'b1 || cfg_data !== mem[8'h10 + i] || cfg_dst !== 2'd1) begin
                failures++;
                $display("FAIL single_word[%0d]: valid %b data %h dst %0d want 1 %h 1", i, cfg_valid, cfg_data, cfg_dst, mem[8'h10 + i]);
            end
        end
        tick();
        checks++; if (done !== 4'b0010 || grant !== '0) begin failures++; $display("FAIL single_done: done %b grant %b want 0010 0000", done, grant); end
        tick();
        checks++; if (done !== '0 || busy !== 1'b0) begin failures++; $display("FAIL single_after: done %b busy %b want 0 0", done, busy); end
        model_rr = 2;
    endtask

    task automatic test_backpressure();
        int g;
        bit ok;
        g = $urandom_range(0, N - 1);
        set_slot(g, $urandom_range(0, 255), 6);
        clear_logs();
        ready_mode = 1;
        req = N'(1) << g;
        tick();
        req = '0;
        wait_dones(1, 200, ok);
        tick();
        checks++; if (!ok || done_q.size() != 1 || done_q[0] != g) begin failures++; $display("FAIL bp_done: got %0d pulses want one for %0d", done_q.size(), g); end
        checks++; if (hs_q.size() != 6) begin failures++; $display("FAIL bp_word_count: got %0d want 6", hs_q.size()); end
        for (int j = 0; j < 6 && j < hs_q.size(); j++) begin
            checks++; if (hs_q[j] !== exp_word(g, j)) begin failures++; $display("FAIL bp_word[%0d]: got %h want %h", j, hs_q[j], exp_word(g, j)); end
        end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stall_err); end
        model_rr = (g + 1) % N;
        ready_mode = 0;
    endtask

    task automatic test_wrap();
        int g;
        bit ok;
        logic [AW-1:0] exp_a;
        g = $urandom_range(0, N - 1);
        set_slot(g, 'hFE, 4);
        clear_logs();
        ready_mode = 2;
        req = N'(1) << g;
        tick();
        req = '0;
        wait_dones(1, 200, ok);
        tick();
        checks++; if (!ok || addr_q.size() != 4) begin failures++; $display("FAIL wrap_reads: got %0d reads want 4", addr_q.size()); end
        for (int j = 0; j < 4 && j < addr_q.size(); j++) begin
            exp_a = AW'(254 + j);
            checks++; if (addr_q[j] !== exp_a) begin failures++; $display("FAIL wrap_addr[%0d]: got %h want %h", j, addr_q[j], exp_a); end
        end
        for (int j = 0; j < 4 && j < hs_q.size(); j++) begin
            checks++; if (hs_q[j] !== exp_word(g, j)) begin failures++; $display("FAIL wrap_word[%0d]: got %h want %h", j, hs_q[j], exp_word(g, j)); end
        end
        model_rr = (g + 1) % N;
        ready_mode = 0;
    endtask

    task automatic test_zero_len();
        bit ok;
        clear_logs();
        set_slot(2, $urandom_range(0, 255), 0);
        req = 4'b0100;
        tick();
        checks++; if (done !== 4'b0100 || grant !== '0) begin failures++; $display("FAIL zero_done: done %b grant %b want 0100 0000", done, grant); end
        checks++; if (mem_rd_en !== 1'b0 || cfg_valid !== 1'b0) begin failures++; $display("FAIL zero_quiet: rd %b valid %b want 0 0", mem_rd_en, cfg_valid); end
        req = '0;
        tick();
        checks++; if (done !== '0 || busy !== 1'b0) begin failures++; $display("FAIL zero_after: done %b busy %b want 0 0", done, busy); end
        checks++; if (addr_q.size() != 0 || hs_q.size() != 0) begin failures++; $display("FAIL zero_no_traffic: reads %0d words %0d want 0 0", addr_q.size(), hs_q.size()); end
        model_rr = 3;
        for (int i = 0; i < N; i++) set_slot(i, $urandom_range(0, 255), 2);
        clear_logs();
        req = 4'b1111;
        tick();
        checks++; if (grant !== (N'(1) << rr_pick(4'b1111, model_rr))) begin failures++; $display("FAIL zero_next_pick: got %b want 1000", grant); end
        req = '0;
        wait_dones(1, 100, ok);
        tick();
        checks++; if (!ok || done_q.size() != 1 || done_q[0] != 3) begin failures++; $display("FAIL zero_next_done: got %0d pulses want one for 3", done_q.size()); end
        model_rr = 0;
    endtask

    task automatic test_reset_mid();
        int g;
        bit ok;
        g = $urandom_range(0, N - 1);
        set_slot(g, $urandom_range(0, 255), 8);
        clear_logs();
        ready_mode = 0;
        req = N'(1) << g;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            tick();
            if (hs_q.size() >= 2) ok = 1'b1;
        end
        checks++; if (!ok) begin failures++; $display("FAIL rmid_progress: got %0d words want 2", hs_q.size()); end
        reset = 1'b1;
        tick();
        checks++;
        if (grant !== '0 || done !== '0 || mem_rd_en !== 1'b0 || cfg_valid !== 1'b0 || busy !== 1'b0 ||
            mem_addr !== '0 || cfg_data !== '0 || cfg_dst !== '0) begin
            failures++;
            $display("FAIL rmid_outputs: grant %b done %b rd %b valid %b busy %b addr %h data %h dst %0d want all 0",
                     grant, done, mem_rd_en, cfg_valid, busy, mem_addr, cfg_data, cfg_dst);
        end
        reset = 1'b0;
        clear_logs();
        model_rr = 0;
        tick();
        checks++; if (grant !== (N'(1) << g)) begin failures++; $display("FAIL rmid_regrant: got %b want %b", grant, N'(1) << g); end
        req = '0;
        wait_dones(1, 100, ok);
        tick();
        checks++; if (!ok || done_q.size() != 1 || done_q[0] != g) begin failures++; $display("FAIL rmid_done: got %0d pulses want one for %0d", done_q.size(), g); end
        checks++; if (hs_q.size() != 8) begin failures++; $display("FAIL rmid_word_count: got %0d want 8", hs_q.size()); end
        for (int j = 0; j < 8 && j < hs_q.size(); j++) begin
            checks++; if (hs_q[j] !== exp_word(g, j)) begin failures++; $display("FAIL rmid_word[%0d]: got %h want %h", j, hs_q[j], exp_word(g, j)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        reset = 1'b1;
        req = '0;
        req_base = '0;
        req_len = '0;
        cfg_ready = 1'b1;
        model_rr = 0;
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
